// File: rtl/gr_load_ctrl_pkg.sv
// Shared opcode, state and decode definitions for the GR load sequencer.
package gr_load_ctrl_pkg;

    // Opcodes carried in instruction word bits [7:4]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDL  = 4'h1;
    localparam logic [3:0] OP_LDH  = 4'h2;
    localparam logic [3:0] OP_LDB  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Sequencer state encodings
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_FETCH_OP = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    // Helper: true for the states that drive a fetch request
    function automatic logic is_fetch_state(input logic [2:0] st);
        return (st == S_FETCH) || (st == S_FETCH_OP);
    endfunction

endpackage

// File: rtl/gr_op_decode.sv
// Combinational opcode decoder: one-hot class flags for a 4-bit opcode.
module gr_op_decode
    import gr_load_ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_ldl_o,
    output logic       is_ldh_o,
    output logic       is_ldb_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    // Classify the opcode; anything undefined is flagged illegal
    always_comb begin
        is_ldl_o     = 1'b0;
        is_ldh_o     = 1'b0;
        is_ldb_o     = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_NOP:  ;
            OP_LDL:  is_ldl_o  = 1'b1;
            OP_LDH:  is_ldh_o  = 1'b1;
            OP_LDB:  is_ldb_o  = 1'b1;
            OP_HALT: is_halt_o = 1'b1;
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/gr_load_ctrl.sv
// Fetch/decode/execute sequencer feeding the general register block.
// All outputs are registered; load strobes are high only in the EXEC cycle.
module gr_load_ctrl
    import gr_load_ctrl_pkg::*;
#(
    parameter int               PC_W     = 8,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] pc,
    input  logic            instr_valid,
    input  logic [7:0]      instr_data,
    output logic [7:0]      data_on_gr,
    output logic            load_lsb_gr,
    output logic            load_msb_gr,
    output logic            halted,
    output logic            illegal_op
);

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      data_q, data_d;
    logic            lsb_q, lsb_d;
    logic            msb_q, msb_d;
    logic            req_q, req_d;
    logic            halt_q, halt_d;
    logic            ill_q, ill_d;

    logic is_ldl, is_ldh, is_ldb, is_halt, is_illegal;
    logic accept;

    gr_op_decode u_dec (
        .opcode_i     (instr_data[7:4]),
        .is_ldl_o     (is_ldl),
        .is_ldh_o     (is_ldh),
        .is_ldb_o     (is_ldb),
        .is_halt_o    (is_halt),
        .is_illegal_o (is_illegal)
    );

    // A word is taken only while our own registered request is up,
    // so stray or late valids (e.g. after a reset) are ignored.
    assign accept = req_q & instr_valid;

    // Next-state, pc and output-register logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        data_d  = data_q;
        lsb_d   = 1'b0;
        msb_d   = 1'b0;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (accept) begin
                    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    if (is_ldb) begin
                        state_d = S_FETCH_OP;
                    end else if (is_halt) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_EXEC;
                        if (is_illegal) ill_d = 1'b1;
                        if (is_ldl) begin
                            data_d = {4'h0, instr_data[3:0]};
                            lsb_d  = 1'b1;
                        end
                        if (is_ldh) begin
                            data_d = {4'h0, instr_data[3:0]};
                            msb_d  = 1'b1;
                        end
                    end
                end
            end
            S_FETCH_OP: begin
                if (accept) begin
                    pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    data_d  = instr_data;
                    lsb_d   = 1'b1;
                    msb_d   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        req_d  = is_fetch_state(state_d);
        halt_d = (state_d == S_HALT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            data_q  <= 8'h00;
            lsb_q   <= 1'b0;
            msb_q   <= 1'b0;
            req_q   <= 1'b0;
            halt_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            lsb_q   <= lsb_d;
            msb_q   <= msb_d;
            req_q   <= req_d;
            halt_q  <= halt_d;
            ill_q   <= ill_d;
        end
    end

    assign instr_req   = req_q;
    assign pc          = pc_q;
    assign data_on_gr  = data_q;
    assign load_lsb_gr = lsb_q;
    assign load_msb_gr = msb_q;
    assign halted      = halt_q;
    assign illegal_op  = ill_q;

endmodule
